// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional perf counters are enabled with HAZ_PERF_CNT_EN.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    REDIRECT,
    DRAIN,
    HALTED
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational operand forwarding and ALU-use / load-use detection
// for the instruction sitting in Execute1.
module hazard_fwd_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs1_e1_i,
  input  logic [4:0] rs2_e1_i,
  input  logic [4:0] rd_e2_i,
  input  logic [4:0] rd_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_e2_i,
  input  logic       reg_write_m_i,
  input  logic       reg_write_w_i,
  input  logic [1:0] result_src_m_i,
  input  logic       valid_e2_i,
  input  logic       valid_m_i,
  input  logic       valid_w_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o,
  output logic       alu_use_o,
  output logic       load_use_o
);

  logic m_ok;
  logic w_ok;
  logic e2_ok;
  logic ld_ok;

  assign m_ok = reg_write_m_i && valid_m_i
             && (rd_m_i != 5'd0)
             && (result_src_m_i != RESULT_LOAD);
  assign w_ok = reg_write_w_i && valid_w_i
             && (rd_w_i != 5'd0);
  assign e2_ok = valid_e2_i && reg_write_e2_i
              && (rd_e2_i != 5'd0);
  assign ld_ok = valid_m_i
              && (result_src_m_i == RESULT_LOAD)
              && (rd_m_i != 5'd0);

  // Nonzero rd implies a nonzero matching source register.
  always_comb begin
    fwd_a_o = FWD_REG;
    if (m_ok && rd_m_i == rs1_e1_i)
      fwd_a_o = FWD_M;
    else if (w_ok && rd_w_i == rs1_e1_i)
      fwd_a_o = FWD_W;
  end

  always_comb begin
    fwd_b_o = FWD_REG;
    if (m_ok && rd_m_i == rs2_e1_i)
      fwd_b_o = FWD_M;
    else if (w_ok && rd_w_i == rs2_e1_i)
      fwd_b_o = FWD_W;
  end

  assign alu_use_o = e2_ok
    && (rd_e2_i == rs1_e1_i
     || rd_e2_i == rs2_e1_i);
  assign load_use_o = ld_ok
    && (rd_m_i == rs1_e1_i
     || rd_m_i == rs2_e1_i);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush/forward control with debug halt drain FSM.
// Define HAZ_PERF_CNT_EN to add stall_cnt / flush_cnt counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E1,
  input  logic [4:0]  Rs2E1,
  input  logic [4:0]  RdE1,
  input  logic [4:0]  RdE2,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteE1,
  input  logic        RegWriteE2,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic [1:0]  ResultSrcE2,
  input  logic [1:0]  ResultSrcM,
  input  logic        ValidD,
  input  logic        ValidE1,
  input  logic        ValidE2,
  input  logic        ValidM,
  input  logic        ValidW,
  input  logic        PCSrcE2,
  input  logic        halt_req,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE1,
  output logic        FlushD,
  output logic        FlushE1,
  output logic        FlushE2,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic        halt_ack
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  state_e     state_q;
  state_e     state_d;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       alu_use;
  logic       load_use;
  logic       taken;
  logic       hz;
  logic       idle;
  logic       unused_in;

  assign unused_in = ^{Rs1D, Rs2D, RdE1,
                       RegWriteE1, ResultSrcE2};

  hazard_fwd_unit u_hfu (
    .rs1_e1_i       (Rs1E1),
    .rs2_e1_i       (Rs2E1),
    .rd_e2_i        (RdE2),
    .rd_m_i         (RdM),
    .rd_w_i         (RdW),
    .reg_write_e2_i (RegWriteE2),
    .reg_write_m_i  (RegWriteM),
    .reg_write_w_i  (RegWriteW),
    .result_src_m_i (ResultSrcM),
    .valid_e2_i     (ValidE2),
    .valid_m_i      (ValidM),
    .valid_w_i      (ValidW),
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b),
    .alu_use_o      (alu_use),
    .load_use_o     (load_use)
  );

  assign taken = PCSrcE2 && ValidE2
              && (state_q != HALTED);
  // E1 holds a bubble right after a redirect.
  assign hz = (alu_use || load_use)
           && (state_q == RUN || state_q == DRAIN);
  assign idle = ~|{ValidD, ValidE1, ValidE2,
                   ValidM, ValidW};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (halt_req)   state_d = DRAIN;
        else if (taken) state_d = REDIRECT;
      end
      REDIRECT: state_d = halt_req ? DRAIN : RUN;
      DRAIN: begin
        if (!halt_req)  state_d = RUN;
        else if (idle)  state_d = HALTED;
      end
      HALTED: if (!halt_req) state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE1  = 1'b0;
    FlushD   = 1'b0;
    FlushE1  = 1'b0;
    FlushE2  = 1'b0;
    ForwardA = FWD_REG;
    ForwardB = FWD_REG;
    halt_ack = 1'b0;
    if (!rst) begin
      ForwardA = fwd_a;
      ForwardB = fwd_b;
      if (taken) begin
        FlushD  = 1'b1;
        FlushE1 = 1'b1;
      end else if (hz) begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallE1 = 1'b1;
        FlushE2 = 1'b1;
      end
      if (state_q == DRAIN || state_q == HALTED) begin
        StallF = 1'b1;
        FlushD = 1'b1;
      end
      halt_ack = (state_q == HALTED);
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF && state_q == RUN
        && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (FlushE1
        && flush_cnt_q != 32'hFFFF_FFFF)
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = rst ? 32'd0 : stall_cnt_q;
  assign flush_cnt = rst ? 32'd0 : flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a rule-level model.
// Build with HAZ_PERF_CNT_EN to also check the perf counters.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E1, Rs2E1;
  logic [4:0] RdE1, RdE2, RdM, RdW;
  logic       RegWriteE1, RegWriteE2;
  logic       RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE2, ResultSrcM;
  logic       ValidD, ValidE1, ValidE2;
  logic       ValidM, ValidW;
  logic       PCSrcE2, halt_req;
  logic       StallF, StallD, StallE1;
  logic       FlushD, FlushE1, FlushE2;
  logic [1:0] ForwardA, ForwardB;
  logic       halt_ack;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] m_scnt, m_fcnt;
`endif

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D),
    .Rs1E1(Rs1E1), .Rs2E1(Rs2E1),
    .RdE1(RdE1), .RdE2(RdE2),
    .RdM(RdM), .RdW(RdW),
    .RegWriteE1(RegWriteE1),
    .RegWriteE2(RegWriteE2),
    .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW),
    .ResultSrcE2(ResultSrcE2),
    .ResultSrcM(ResultSrcM),
    .ValidD(ValidD), .ValidE1(ValidE1),
    .ValidE2(ValidE2), .ValidM(ValidM),
    .ValidW(ValidW),
    .PCSrcE2(PCSrcE2), .halt_req(halt_req),
    .StallF(StallF), .StallD(StallD),
    .StallE1(StallE1),
    .FlushD(FlushD), .FlushE1(FlushE1),
    .FlushE2(FlushE2),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .halt_ack(halt_ack)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Model: mode of the controller per the rules.
  localparam int M_RUN   = 0;
  localparam int M_REDIR = 1;
  localparam int M_DRAIN = 2;
  localparam int M_HALT  = 3;
  int mode = M_RUN;

  typedef struct packed {
    logic sf, sd, se, fd, fe1, fe2, ack;
    logic [1:0] fa, fb;
  } exp_t;

  function automatic logic [1:0] exp_fwd(
      input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (RegWriteM && ValidM && RdM == rs
        && ResultSrcM != 2'b01) return 2'b10;
    if (RegWriteW && ValidW && RdW == rs)
      return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t expect_out();
    exp_t e;
    logic br, hz;
    logic [4:0] rs [2];
    e = '0;
    if (rst) return e;
    e.fa = exp_fwd(Rs1E1);
    e.fb = exp_fwd(Rs2E1);
    rs[0] = Rs1E1;
    rs[1] = Rs2E1;
    hz = 1'b0;
    foreach (rs[i]) if (rs[i] != 5'd0) begin
      if (ValidE2 && RegWriteE2 && RdE2 == rs[i])
        hz = 1'b1;
      if (ValidM && ResultSrcM == 2'b01
          && RdM == rs[i]) hz = 1'b1;
    end
    if (mode == M_REDIR || mode == M_HALT)
      hz = 1'b0;
    br = PCSrcE2 && ValidE2 && mode != M_HALT;
    if (br) begin
      e.fd = 1'b1; e.fe1 = 1'b1;
    end else if (hz) begin
      e.sf = 1'b1; e.sd = 1'b1;
      e.se = 1'b1; e.fe2 = 1'b1;
    end
    if (mode == M_DRAIN || mode == M_HALT) begin
      e.sf = 1'b1; e.fd = 1'b1;
    end
    e.ack = (mode == M_HALT);
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    logic idle;
    e = expect_out();
    idle = !(ValidD || ValidE1 || ValidE2
             || ValidM || ValidW);
`ifdef HAZ_PERF_CNT_EN
    if (rst) begin
      m_scnt = 0; m_fcnt = 0;
    end else begin
      if (e.sf && mode == M_RUN && m_scnt != '1)
        m_scnt = m_scnt + 1;
      if (e.fe1 && m_fcnt != '1)
        m_fcnt = m_fcnt + 1;
    end
`endif
    if (rst) mode = M_RUN;
    else case (mode)
      M_RUN:
        if (halt_req) mode = M_DRAIN;
        else if (PCSrcE2 && ValidE2)
          mode = M_REDIR;
      M_REDIR: mode = halt_req ? M_DRAIN : M_RUN;
      M_DRAIN:
        if (!halt_req) mode = M_RUN;
        else if (idle) mode = M_HALT;
      default: if (!halt_req) mode = M_RUN;
    endcase
  end

  task automatic compare();
    exp_t e;
    e = expect_out();
    chk("StallF", 32'(StallF), 32'(e.sf));
    chk("StallD", 32'(StallD), 32'(e.sd));
    chk("StallE1", 32'(StallE1), 32'(e.se));
    chk("FlushD", 32'(FlushD), 32'(e.fd));
    chk("FlushE1", 32'(FlushE1), 32'(e.fe1));
    chk("FlushE2", 32'(FlushE2), 32'(e.fe2));
    chk("ForwardA", 32'(ForwardA), 32'(e.fa));
    chk("ForwardB", 32'(ForwardB), 32'(e.fb));
    chk("halt_ack", 32'(halt_ack), 32'(e.ack));
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_scnt);
    chk("flush_cnt", flush_cnt, m_fcnt);
`endif
  endtask

  always @(negedge clk) begin
    #2;
    if (chk_en) compare();
  end

  task automatic clr();
    Rs1D = 0; Rs2D = 0; Rs1E1 = 0; Rs2E1 = 0;
    RdE1 = 0; RdE2 = 0; RdM = 0; RdW = 0;
    RegWriteE1 = 0; RegWriteE2 = 0;
    RegWriteM = 0; RegWriteW = 0;
    ResultSrcE2 = 0; ResultSrcM = 0;
    ValidD = 0; ValidE1 = 0; ValidE2 = 0;
    ValidM = 0; ValidW = 0;
    PCSrcE2 = 0; halt_req = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    clr();
  endtask

  task automatic vld(input logic [4:0] v);
    {ValidD, ValidE1, ValidE2, ValidM, ValidW} = v;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    chk_en = 1'b1;
    // reset: matching inputs must not forward
    cyc();
    RdM = 5; RegWriteM = 1; ValidM = 1;
    Rs1E1 = 5;
    #3 chk("rst_fwdA", 32'(ForwardA), 32'd0);
    cyc();
    RdE2 = 4; RegWriteE2 = 1; ValidE2 = 1;
    Rs2E1 = 4;
    #3 chk("rst_stallF", 32'(StallF), 32'd0);
    // forward from M
    cyc(); rst = 1'b0;
    RdM = 5; RegWriteM = 1; ValidM = 1;
    Rs1E1 = 5;
    #3 chk("fwdM_A", 32'(ForwardA), 32'd2);
    chk("fwdM_nostall", 32'(StallF), 32'd0);
    // M over W, then W alone
    cyc();
    RdM = 7; RdW = 7; RegWriteM = 1;
    RegWriteW = 1; ValidM = 1; ValidW = 1;
    Rs2E1 = 7;
    #3 chk("prio_B_M", 32'(ForwardB), 32'd2);
    cyc();
    RdM = 7; RdW = 7; RegWriteW = 1;
    ValidM = 1; ValidW = 1; Rs2E1 = 7;
    #3 chk("prio_B_W", 32'(ForwardB), 32'd1);
    // load-use stall, then load in W
    cyc();
    ResultSrcM = 2'b01; RdM = 3; RegWriteM = 1;
    ValidM = 1; Rs1E1 = 3;
    #3 chk("ld_stallE1", 32'(StallE1), 32'd1);
    chk("ld_flushE2", 32'(FlushE2), 32'd1);
    chk("ld_fwdA", 32'(ForwardA), 32'd0);
    cyc();
    RdW = 3; RegWriteW = 1; ValidW = 1;
    Rs1E1 = 3;
    #3 chk("ld_done", 32'(StallF), 32'd0);
    chk("ld_fwdW", 32'(ForwardA), 32'd1);
    cyc();
    ResultSrcM = 2'b01; RdM = 0; RegWriteM = 1;
    ValidM = 1; Rs1E1 = 0;
    #3 chk("ld_x0", 32'(StallF), 32'd0);
    // ALU-use stall, then M forwarding
    cyc();
    RdE2 = 4; RegWriteE2 = 1; ValidE2 = 1;
    Rs2E1 = 4;
    #3 chk("alu_stallD", 32'(StallD), 32'd1);
    cyc();
    RdM = 4; RegWriteM = 1; ValidM = 1;
    Rs2E1 = 4;
    #3 chk("alu_fwdM", 32'(ForwardB), 32'd2);
    // branch overrides stall, then bubble cycle
    cyc();
    PCSrcE2 = 1; RdE2 = 4; RegWriteE2 = 1;
    ValidE2 = 1; Rs1E1 = 4;
    #3 chk("br_flushE1", 32'(FlushE1), 32'd1);
    chk("br_nostall", 32'(StallF), 32'd0);
    cyc();
    RdE2 = 4; RegWriteE2 = 1; ValidE2 = 1;
    Rs1E1 = 4;
    #3 chk("br_after", 32'(StallF), 32'd0);
    cyc();
    RdE2 = 4; RegWriteE2 = 1; ValidE2 = 1;
    Rs1E1 = 4;
    #3 chk("br_rerun", 32'(StallF), 32'd1);
    // halt with three in flight
    cyc(); halt_req = 1; vld(5'b11100);
    #3 chk("h_run_ack", 32'(halt_ack), 32'd0);
    cyc(); halt_req = 1; vld(5'b01110);
    #3 chk("h_drain_fd", 32'(FlushD), 32'd1);
    chk("h_drain_ack", 32'(halt_ack), 32'd0);
    cyc(); halt_req = 1; vld(5'b00111);
    cyc(); halt_req = 1; vld(5'b00011);
    cyc(); halt_req = 1; vld(5'b00001);
    cyc(); halt_req = 1;
    #3 chk("h_last_ack", 32'(halt_ack), 32'd0);
    cyc(); halt_req = 1;
    #3 chk("h_ack", 32'(halt_ack), 32'd1);
    chk("h_stallF", 32'(StallF), 32'd1);
    cyc();
    #3 chk("h_drop_ack", 32'(halt_ack), 32'd1);
    cyc();
    #3 chk("h_run", 32'(halt_ack), 32'd0);
    chk("h_run_fd", 32'(FlushD), 32'd0);
    // halt_req drop mid-drain returns to RUN
    cyc(); halt_req = 1; vld(5'b00001);
    cyc(); vld(5'b00001);
    #3 chk("dr_drop", 32'(StallF), 32'd1);
    cyc();
    #3 chk("dr_run", 32'(StallF), 32'd0);
    // reset mid-drain
    cyc(); halt_req = 1; vld(5'b00011);
    cyc(); halt_req = 1; vld(5'b00001);
    #3 chk("rd_drain", 32'(StallF), 32'd1);
    cyc(); rst = 1'b1; halt_req = 1;
    vld(5'b00001);
    #3 chk("rd_stallF", 32'(StallF), 32'd0);
    chk("rd_flushD", 32'(FlushD), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("rd_scnt", stall_cnt, 32'd0);
    chk("rd_fcnt", flush_cnt, 32'd0);
`endif
    cyc(); rst = 1'b0;
    #3 chk("rd_run", 32'(StallF), 32'd0);
    chk("rd_ack", 32'(halt_ack), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("rd_scnt0", stall_cnt, 32'd0);
`endif
    cyc();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL provide these ports, in this order:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- Rs1D, Rs2D  in  5  source register numbers of the instruction in Decode.
- Rs1E1, Rs2E1  in  5  source register numbers of the instruction in Execute1.
- RdE1, RdE2, RdM, RdW  in  5  destination register numbers per stage.
- RegWriteE1, RegWriteE2, RegWriteM, RegWriteW  in  1  per-stage register-write enables.
- ResultSrcE2, ResultSrcM  in  2  result-source code; 2'b01 = load.
- ValidD, ValidE1, ValidE2, ValidM, ValidW  in  1  per-stage instruction-valid flags.
- PCSrcE2  in  1  branch/jump taken, resolved in Execute2.
- halt_req  in  1  debug halt request; level-sensitive.
- StallF, StallD, StallE1  out  1  hold the corresponding pipeline register.
- FlushD, FlushE1, FlushE2  out  1  insert a bubble into the corresponding pipeline register.
- ForwardA, ForwardB  out  2  ALU operand select: 00 = register value, 01 = W result, 10 = M ALU result.
- halt_ack  out  1  pipeline is drained and halted.
- stall_cnt, flush_cnt  out  32  performance counters; present only under HAZ_PERF_CNT_EN.

Function
REQ-002 Forwarding SHALL be combinational and apply separately to Rs1E1 (ForwardA) and Rs2E1 (ForwardB).
- Select 10 when RegWriteM, ValidM, RdM == RsE1, RdM != 0 and ResultSrcM != 01.
- Otherwise select 01 when RegWriteW, ValidW, RdW == RsE1 and RdW != 0.
- Otherwise select 00.
REQ-003 M has priority over W when both match.
REQ-004 An operand match SHALL count only for a nonzero source register.
REQ-005 ALU-use hazard: asserted when ValidE2, RegWriteE2, RdE2 != 0 and RdE2 equals Rs1E1 or Rs2E1.
REQ-006 Load-use hazard: asserted when ValidM, ResultSrcM == 01, RdM != 0 and RdM equals Rs1E1 or Rs2E1.
REQ-007 While either hazard is asserted in RUN, the block SHALL assert StallF, StallD and StallE1, and assert FlushE2 to inject a bubble.
REQ-008 A stall SHALL last until the hazard clears. An ALU-use stall is exactly 1 cycle; a load-use stall is exactly 1 cycle.
REQ-009 When PCSrcE2 = 1 and ValidE2 = 1, the block SHALL assert FlushD and FlushE1 in the same cycle, with no stall outputs asserted.
REQ-010 A branch flush SHALL override any simultaneous stall.
REQ-011 On the cycle after a branch flush, hazard detection SHALL be suppressed, because E1 holds a bubble.
REQ-012 The state machine SHALL have the states RUN, REDIRECT, DRAIN and HALTED.
- RUN -> REDIRECT on a taken branch.
- REDIRECT -> RUN after 1 cycle.
- RUN or REDIRECT -> DRAIN when halt_req = 1.
- DRAIN -> HALTED when ValidD, ValidE1, ValidE2, ValidM and ValidW are all 0.
- HALTED -> RUN when halt_req = 0.
REQ-013 In DRAIN, the block SHALL assert StallF and FlushD each cycle so that no new instruction enters. Older instructions SHALL proceed with normal hazard handling.
REQ-014 A taken branch during DRAIN SHALL flush as in REQ-009 and remain in DRAIN.
REQ-015 In HALTED, the block SHALL assert halt_ack = 1, StallF = 1 and FlushD = 1. halt_ack SHALL be 0 in every other state.
REQ-016 If halt_req deasserts while in DRAIN, the block SHALL return to RUN on the next cycle.

Reset
REQ-017 While rst = 1, the state SHALL be RUN and all outputs 0, including ForwardA/B = 00 and the counters = 0.
REQ-018 rst SHALL take precedence over every input, including mid-DRAIN and mid-stall.

Configuration
REQ-019 With HAZ_PERF_CNT_EN defined, the block SHALL provide the counters and their ports.
- stall_cnt increments each cycle StallF is asserted in RUN.
- flush_cnt increments each cycle FlushE1 is asserted.
- Both counters saturate at 32'hFFFF_FFFF.
REQ-020 Without HAZ_PERF_CNT_EN, the counter ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-021 A shared package SHALL hold:
- the state enum (RUN, REDIRECT, DRAIN, HALTED);
- the FWD_REG, FWD_W and FWD_M constants;
- the RESULT_LOAD = 2'b01 constant.
REQ-022 There SHALL be one sub-module, hazard_fwd_unit, containing the combinational forwarding and hazard-detect logic. The FSM and counters SHALL live in the top-level block.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Forward from M: RdM = 5, RegWriteM = 1, ResultSrcM = 00, Rs1E1 = 5 -> ForwardA = 10, no stall.
- Forward priority: RdM = RdW = 7, both writing, Rs2E1 = 7 -> ForwardB = 10; clear RegWriteM -> ForwardB = 01.
- Load-use: ResultSrcM = 01, RdM = 3, Rs1E1 = 3 -> StallF/D/E1 = 1 and FlushE2 = 1 for 1 cycle; Rs1E1 = 0 with RdM = 0 -> no stall.
- Branch and stall together: PCSrcE2 = 1 with an ALU-use hazard present -> FlushD = FlushE1 = 1 and stalls = 0; the next cycle shows no stall.
- Halt: halt_req = 1 with 3 instructions in flight -> halt_ack = 1 once all Valid* = 0; drop halt_req -> RUN and halt_ack = 0 the next cycle.
- Reset mid-DRAIN: rst = 1 for one cycle -> state RUN, all outputs 0; with HAZ_PERF_CNT_EN, counters = 0.
